// File: rtl/seq_step_ctrl.sv
// Steps through the first len entries of a 4-entry programmable table, holding each value div+1 cycles, in one-shot or loop mode.
// One cycle from start to the first q; all outputs registered, no flow control (stop aborts the run, rst clears everything).
module seq_step_ctrl #(
    parameter int WIDTH = 3,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic [2:0]       len,
    input  logic [DIV_W-1:0] div,
    input  logic             loop,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] q,
    output logic [1:0]       idx,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] tbl [4];
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_l;
    logic [1:0]       last_l;
    logic             loop_l;
    logic [1:0]       last_in;
    logic             tick;

    // Out-of-range lengths (0, 5..7) play the whole table.
    always_comb begin
        last_in = 2'd3;
        if (len != 3'd0 && len <= 3'd4)
            last_in = 2'(len - 3'd1);
    end

    assign tick = (cnt == div_l);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            q      <= '0;
            idx    <= 2'd0;
            valid  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            div_l  <= '0;
            last_l <= 2'd0;
            loop_l <= 1'b0;
            tbl[0] <= WIDTH'(0);
            tbl[1] <= WIDTH'(2);
            tbl[2] <= WIDTH'(4);
            tbl[3] <= WIDTH'(7);
        end else begin
            valid <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        div_l  <= div;
                        last_l <= last_in;
                        loop_l <= loop;
                        cnt    <= '0;
                        idx    <= 2'd0;
                        q      <= tbl[0];
                        valid  <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (tick) begin
                        cnt <= '0;
                        if (idx != last_l) begin
                            idx   <= idx + 2'd1;
                            q     <= tbl[idx + 2'd1];
                            valid <= 1'b1;
                        end else if (loop_l) begin
                            idx   <= 2'd0;
                            q     <= tbl[0];
                            valid <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // Reads above see the pre-write table, so a write never alters a q loaded on the same edge.
            if (cfg_we)
                tbl[cfg_addr] <= cfg_data;
        end
    end

endmodule

// File: doc/seq_step_ctrl.md
# seq_step_ctrl

Programmable controller for the 3-bit sequence-generator datapath. Holds a 4-entry value table that resets to 0-2-4-7 and steps through the first `len` entries at a programmable rate, in one-shot or loop mode. Provides start/stop control and status (`valid`, `busy`, `done`) for the surrounding system. Sits between the system control register file and any logic consuming the generated sequence.

## Interface
Parameters:
- WIDTH, 3: bit width of table entries and `q`; must be ≥ 3.
- DIV_W, 8: bit width of the step divider.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  2  table entry index (0..3).
- cfg_data  in  WIDTH  value written to the entry at `cfg_addr`.
- len  in  3  number of entries to play; sampled at start.
- div  in  DIV_W  extra hold cycles per step; sampled at start.
- loop  in  1  1 = wrap to entry 0 after the last entry; 0 = one-shot; sampled at start.
- start  in  1  begin a run; level-sampled.
- stop  in  1  abort a run.
- q  out  WIDTH  current sequence value (registered).
- idx  out  2  table index of current `q`.
- valid  out  1  1-cycle pulse when `q` loads a new value.
- busy  out  1  high while running.
- done  out  1  1-cycle pulse on one-shot completion.

## Operation
- Reset: `q`=0, `idx`=0, `valid`=0, `busy`=0, `done`=0, state IDLE, hold counter=0, table={0,2,4,7}. Reset overrides all other inputs.
- Table writes (`cfg_we`) are accepted in any state. A written entry takes effect the next time that entry is loaded; a `q` already loaded is not changed.
- Length rule: if `len`=0 or `len`>4, the run uses 4 entries. `last` = effective length − 1.
- States:
  - IDLE: `busy`=0; `q` and `idx` hold their last values.
    - `start`=1 and `stop`=0 → RUN. Latch `len`, `div` and `loop`. Load `q`=table[0] and `idx`=0, clear the counter, pulse `valid`.
  - RUN: `busy`=1.
    - The counter increments each cycle. When counter==div_latched (a "tick"), the counter clears and the run advances.
    - Advance with `idx`<last: `idx`+1, `q`=table[`idx`+1], pulse `valid`.
    - Advance with `idx`==last and loop=1: `idx`=0, `q`=table[0], pulse `valid`.
    - Advance with `idx`==last and loop=0: → IDLE, pulse `done`. `q` and `idx` hold the last entry; `valid`=0.
    - `stop`=1: → IDLE next edge. No `done`, no `valid`; `q` and `idx` hold.
- Priority: `rst` > `stop` > tick > `start`.
  - `start` during RUN is ignored; `len`, `div` and `loop` changes during RUN are ignored.
  - `start` and `stop` asserted together in IDLE: remain IDLE.
- `start` held high after a one-shot completes restarts on the cycle after `done`. The new run's first `valid` follows the `done` pulse by one cycle.

## Timing
- `start` sampled at edge T: at T+1, `busy`=1, `q`=table[0], `valid`=1.
- Each value is held div+1 cycles. With div=D, `q` updates at T+1, T+1+(D+1), T+1+2(D+1), …
- One-shot end, with L = effective length: `done`=1 and `busy`=0 at T+1+L(D+1), for exactly one cycle.
- `stop` sampled at edge S: `busy`=0 at S+1.
- `rst` sampled at edge R: all outputs at their reset values at R+1, including mid-run and the table contents.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- Reset, div=0, len=4, loop=0, pulse `start` at T → `q`=0,2,4,7 at T+1..T+4; `valid`=1 at each of those edges; `done`=1 at T+5 only; `q` holds 7 afterwards.
- div=2, len=4, loop=1 → each value held 3 cycles; sequence 0,2,4,7,0,2,…; `done` never asserts; `busy` stays 1.
- Write table to {5,1,6,3}, len=2, div=0, one-shot → `q`=5,1 then `done`. Then len=0 → `q`=5,1,6,3 (treated as 4 entries).
- `stop` asserted while `idx`=2 → `busy`=0 next cycle; `q`=4 holds; no `done` pulse. Then `start`+`stop` together in IDLE → stays IDLE.
- `rst` asserted mid-run after the table was rewritten → next cycle `q`=0, `busy`=0; the table reads back 0,2,4,7 on the following run.
- Write entry 3 while `idx`=1 in a running sequence → the new value appears when `idx` reaches 3. Rewrite entry 1 at the same time → `q` does not change until entry 1 is next loaded.
